// File: rtl/vx_warp_fetch_sched_pkg.sv
// Shared scheduler/fetch types: warp-id width helper and the issue record handed to fetch.
package VX_gpu_pkg;

  localparam int DEF_NUM_WARPS   = 4;
  localparam int DEF_NUM_THREADS = 4;
  localparam int DEF_XLEN        = 32;
  localparam int DEF_UUID_WIDTH  = 44;

  function automatic int nw_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NW_WIDTH = nw_bits(DEF_NUM_WARPS);

  typedef struct packed {
    logic [DEF_UUID_WIDTH-1:0]  uuid;
    logic [NW_WIDTH-1:0]        wid;
    logic [DEF_NUM_THREADS-1:0] tmask;
    logic [DEF_XLEN-1:0]        PC;
  } sched_data_t;

endpackage

// File: rtl/vx_warp_fetch_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the slot following the last grant.
module VX_rr_arbiter
  import VX_gpu_pkg::*;
#(
  parameter int NUM_REQS = 4,
  localparam int IDX_W = nw_bits(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                enable,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_index
);

  // ptr holds the first slot to consider, i.e. last grant + 1
  logic [IDX_W-1:0] ptr;

  always_comb begin
    int cand;
    logic [IDX_W-1:0] cidx;
    grant_valid = 1'b0;
    grant_index = '0;
    cand        = 0;
    cidx        = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      cand = (int'(ptr) + i) % NUM_REQS;
      cidx = IDX_W'(cand);
      if (!grant_valid && requests[cidx]) begin
        grant_valid = 1'b1;
        grant_index = cidx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (enable && grant_valid) begin
      ptr <= IDX_W'((int'(grant_index) + 1) % NUM_REQS);
    end
  end

endmodule

// File: rtl/vx_warp_fetch_sched.sv
// Warp scheduler for the fetch stage: per-warp PC/mask/stall state, round-robin pick,
// and a valid/ready output register allowing one in-flight instruction per warp.
module vx_warp_fetch_sched
  import VX_gpu_pkg::*;
#(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int UUID_WIDTH  = 44,
  parameter logic [XLEN-1:0] STARTUP_ADDR = XLEN'(32'h80000000),
  localparam int WID_W = nw_bits(NUM_WARPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   spawn_valid,
  input  logic [NUM_WARPS-1:0]   spawn_wmask,
  input  logic [XLEN-1:0]        spawn_pc,
  input  logic                   unlock_valid,
  input  logic [WID_W-1:0]       unlock_wid,
  input  logic                   branch_valid,
  input  logic [WID_W-1:0]       branch_wid,
  input  logic                   branch_taken,
  input  logic [XLEN-1:0]        branch_dest,
  input  logic                   tmc_valid,
  input  logic [WID_W-1:0]       tmc_wid,
  input  logic [NUM_THREADS-1:0] tmc_tmask,
  output logic                   sched_valid,
  input  logic                   sched_ready,
  output logic [WID_W-1:0]       sched_wid,
  output logic [XLEN-1:0]        sched_pc,
  output logic [NUM_THREADS-1:0] sched_tmask,
  output logic [UUID_WIDTH-1:0]  sched_uuid,
  output logic [NUM_WARPS-1:0]   active_warps,
  output logic                   busy
);

  typedef struct packed {
    logic [UUID_WIDTH-1:0]  uuid;
    logic [WID_W-1:0]       wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [XLEN-1:0]        pc;
  } out_t;

  logic [NUM_WARPS-1:0]   active_q;
  logic [NUM_WARPS-1:0]   stalled_q;
  logic [NUM_WARPS-1:0]   eligible;
  logic [XLEN-1:0]        pc_q    [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
  logic [UUID_WIDTH-1:0]  uuid_q;

  out_t out_p0;
  logic vld_p0;

  logic             load_en;
  logic             do_load;
  logic             grant_valid;
  logic [WID_W-1:0] grant_idx;

  assign eligible = active_q & ~stalled_q;
  assign load_en  = !vld_p0 || sched_ready;
  assign do_load  = load_en && grant_valid;

  VX_rr_arbiter #(
    .NUM_REQS (NUM_WARPS)
  ) rr_arb (
    .clk         (clk),
    .reset       (reset),
    .requests    (eligible),
    .enable      (load_en),
    .grant_valid (grant_valid),
    .grant_index (grant_idx)
  );

  // Load is applied first; later events override it, so an event's stall
  // clear or branch target wins over the load's stall set and PC+4.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q  <= '0;
      stalled_q <= '0;
      uuid_q    <= '0;
      vld_p0    <= 1'b0;
      out_p0    <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w]    <= '0;
        tmask_q[w] <= '0;
      end
    end else begin
      if (load_en) begin
        vld_p0 <= grant_valid;
        if (grant_valid) begin
          out_p0.uuid          <= uuid_q;
          out_p0.wid           <= grant_idx;
          out_p0.tmask         <= tmask_q[grant_idx];
          out_p0.pc            <= pc_q[grant_idx];
          uuid_q               <= uuid_q + UUID_WIDTH'(1);
          stalled_q[grant_idx] <= 1'b1;
          pc_q[grant_idx]      <= pc_q[grant_idx] + XLEN'(4);
        end
      end

      if (start && !active_q[0]) begin
        active_q[0]  <= 1'b1;
        stalled_q[0] <= 1'b0;
        pc_q[0]      <= STARTUP_ADDR;
        tmask_q[0]   <= '1;
      end

      for (int w = 0; w < NUM_WARPS; w++) begin
        if (spawn_valid && spawn_wmask[w] && !active_q[w]) begin
          active_q[w]  <= 1'b1;
          stalled_q[w] <= 1'b0;
          pc_q[w]      <= spawn_pc;
          tmask_q[w]   <= '1;
        end
      end

      if (branch_valid && active_q[branch_wid]) begin
        stalled_q[branch_wid] <= 1'b0;
        if (branch_taken) begin
          pc_q[branch_wid] <= branch_dest;
        end
      end

      if (tmc_valid && active_q[tmc_wid]) begin
        stalled_q[tmc_wid] <= 1'b0;
        tmask_q[tmc_wid]   <= tmc_tmask;
        if (tmc_tmask == '0) begin
          active_q[tmc_wid] <= 1'b0;
        end
      end

      if (unlock_valid && active_q[unlock_wid]) begin
        stalled_q[unlock_wid] <= 1'b0;
      end
    end
  end

  assign sched_valid  = vld_p0;
  assign sched_wid    = out_p0.wid;
  assign sched_pc     = out_p0.pc;
  assign sched_tmask  = out_p0.tmask;
  assign sched_uuid   = out_p0.uuid;
  assign active_warps = active_q;
  assign busy         = |active_q;

  // A warp being issued is not stalled, so no resolution event can legally target it.
  logic event_on_loaded;
  assign event_on_loaded = do_load &&
                           ((unlock_valid && unlock_wid == grant_idx) ||
                            (branch_valid && branch_wid == grant_idx) ||
                            (tmc_valid    && tmc_wid    == grant_idx));

  a_pc_nonzero: assert property (@(posedge clk) disable iff (!reset)
    vld_p0 |-> (out_p0.pc != '0));
  a_unlock_active: assert property (@(posedge clk) disable iff (!reset)
    unlock_valid |-> active_q[unlock_wid]);
  a_branch_active: assert property (@(posedge clk) disable iff (!reset)
    branch_valid |-> active_q[branch_wid]);
  a_tmc_active: assert property (@(posedge clk) disable iff (!reset)
    tmc_valid |-> active_q[tmc_wid]);
  a_event_vs_load: assert property (@(posedge clk) disable iff (!reset)
    !event_on_loaded);

endmodule

// File: tb/tb_vx_warp_fetch_sched.sv
// Bench for vx_warp_fetch_sched: per-cycle vector table plus an issue scoreboard checked on every fire.
module tb_vx_warp_fetch_sched;

  localparam logic [31:0] B = 32'h80000000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        spawn_valid;
  logic [3:0]  spawn_wmask;
  logic [31:0] spawn_pc;
  logic        unlock_valid;
  logic [1:0]  unlock_wid;
  logic        branch_valid;
  logic [1:0]  branch_wid;
  logic        branch_taken;
  logic [31:0] branch_dest;
  logic        tmc_valid;
  logic [1:0]  tmc_wid;
  logic [3:0]  tmc_tmask;
  logic        sched_valid;
  logic        sched_ready;
  logic [1:0]  sched_wid;
  logic [31:0] sched_pc;
  logic [3:0]  sched_tmask;
  logic [43:0] sched_uuid;
  logic [3:0]  active_warps;
  logic        busy;

  vx_warp_fetch_sched dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .spawn_valid  (spawn_valid),
    .spawn_wmask  (spawn_wmask),
    .spawn_pc     (spawn_pc),
    .unlock_valid (unlock_valid),
    .unlock_wid   (unlock_wid),
    .branch_valid (branch_valid),
    .branch_wid   (branch_wid),
    .branch_taken (branch_taken),
    .branch_dest  (branch_dest),
    .tmc_valid    (tmc_valid),
    .tmc_wid      (tmc_wid),
    .tmc_tmask    (tmc_tmask),
    .sched_valid  (sched_valid),
    .sched_ready  (sched_ready),
    .sched_wid    (sched_wid),
    .sched_pc     (sched_pc),
    .sched_tmask  (sched_tmask),
    .sched_uuid   (sched_uuid),
    .active_warps (active_warps),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wid;
    logic [31:0] pc;
    logic [3:0]  tmask;
    logic [43:0] uuid;
  } issue_t;

  typedef struct {
    logic        start;
    logic [3:0]  spawn;
    logic [31:0] spc;
    logic        ul_v;
    logic [1:0]  ul_w;
    logic        br_v;
    logic [1:0]  br_w;
    logic        br_t;
    logic [31:0] br_d;
    logic        tm_v;
    logic [1:0]  tm_w;
    logic [3:0]  tm_m;
    logic        rdy;
    logic        e_v;
    logic [1:0]  e_w;
    logic [31:0] e_pc;
    logic [3:0]  e_tm;
    logic [43:0] e_uid;
    logic [3:0]  e_act;
    logic        nw;
  } vec_t;

  issue_t exp_q[$];
  vec_t   tbl[$];
  int     checks = 0;
  int     errors = 0;
  int     fires  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; spawn_valid = 0; spawn_wmask = 0; spawn_pc = 0;
    unlock_valid = 0; unlock_wid = 0;
    branch_valid = 0; branch_wid = 0; branch_taken = 0; branch_dest = 0;
    tmc_valid = 0; tmc_wid = 0; tmc_tmask = 0;
  endtask

  function automatic vec_t v(input logic st, input logic [3:0] sp, input logic [31:0] spc,
                             input logic ulv, input logic [1:0] ulw,
                             input logic brv, input logic [1:0] brw, input logic brt, input logic [31:0] brd,
                             input logic tmv, input logic [1:0] tmw, input logic [3:0] tmm,
                             input logic rdy, input logic ev, input logic [1:0] ew, input logic [31:0] epc,
                             input logic [3:0] etm, input int euid, input logic [3:0] eact, input logic nw);
    vec_t r;
    r.start = st; r.spawn = sp; r.spc = spc; r.ul_v = ulv; r.ul_w = ulw;
    r.br_v = brv; r.br_w = brw; r.br_t = brt; r.br_d = brd;
    r.tm_v = tmv; r.tm_w = tmw; r.tm_m = tmm; r.rdy = rdy;
    r.e_v = ev; r.e_w = ew; r.e_pc = epc; r.e_tm = etm; r.e_uid = 44'(euid); r.e_act = eact; r.nw = nw;
    return r;
  endfunction

  // Scoreboard: every accepted transfer must match the oldest expected issue.
  always @(posedge clk) begin
    issue_t e;
    if (reset && sched_valid && sched_ready) begin
      fires++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fire_unexpected: got wid=%0d pc=%0h uuid=%0d with nothing expected",
                 sched_wid, sched_pc, sched_uuid);
      end else begin
        e = exp_q.pop_front();
        if (sched_wid !== e.wid || sched_pc !== e.pc || sched_tmask !== e.tmask || sched_uuid !== e.uuid) begin
          errors++;
          $display("FAIL fire_%0d: got wid=%0d pc=%0h tm=%0h uuid=%0d expected wid=%0d pc=%0h tm=%0h uuid=%0d",
                   fires, sched_wid, sched_pc, sched_tmask, sched_uuid, e.wid, e.pc, e.tmask, e.uuid);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within limit");
    $fatal(1, "timeout");
  end

  initial begin
    int f0;
    issue_t it;
    clear_inputs();
    sched_ready = 1;
    reset = 1;
    #1 reset = 0;
    #2;
    chk("rst_valid", sched_valid, 0);
    chk("rst_active", active_warps, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pc", sched_pc, 0);
    chk("rst_uuid", sched_uuid, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    tick();

    //          st sp    spc    ulv ulw brv brw brt brd        tmv tmw tmm  rdy ev ew epc       etm  uid act   nw
    tbl.push_back(v(1, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 0, 0, 0,        4'hF, 0,  4'h1, 0));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 1, 0, B,        4'hF, 0,  4'h1, 1));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 0, 0, 0,        4'hF, 0,  4'h1, 0));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 0, 0, 0,        4'hF, 0,  4'h1, 0));
    tbl.push_back(v(0, 4'h0, 0,     1, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 0, 0, 0,        4'hF, 0,  4'h1, 0));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 1, 0, B+4,      4'hF, 1,  4'h1, 1));
    tbl.push_back(v(0, 4'hE, 'h100, 0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 0, 0, 0,        4'hF, 0,  4'hF, 0));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 1, 1, 'h100,    4'hF, 2,  4'hF, 1));
    tbl.push_back(v(0, 4'h0, 0,     1, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 1, 2, 'h100,    4'hF, 3,  4'hF, 1));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 1, 3, 'h100,    4'hF, 4,  4'hF, 1));
    tbl.push_back(v(0, 4'h0, 0,     1, 1, 0, 0, 0, 0,          0, 0, 4'h0, 1, 1, 0, B+8,      4'hF, 5,  4'hF, 1));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 1, 1, 'h104,    4'hF, 6,  4'hF, 1));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 0, 0, 0,        4'hF, 0,  4'hF, 0));
    tbl.push_back(v(0, 4'h0, 0,     1, 2, 0, 0, 0, 0,          0, 0, 4'h0, 0, 0, 0, 0,        4'hF, 0,  4'hF, 0));
    tbl.push_back(v(0, 4'h0, 0,     1, 3, 0, 0, 0, 0,          0, 0, 4'h0, 0, 1, 2, 'h104,    4'hF, 7,  4'hF, 1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(v(0, 4'h0, 0,   0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 0, 1, 2, 'h104,    4'hF, 7,  4'hF, 0));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 1, 3, 'h104,    4'hF, 8,  4'hF, 1));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 0, 0, 0,        4'hF, 0,  4'hF, 0));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 1, 0, 1, B+'h40,     0, 0, 4'h0, 1, 0, 0, 0,        4'hF, 0,  4'hF, 0));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 1, 0, B+'h40,   4'hF, 9,  4'hF, 1));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 1, 0, 0, 'h12345678, 0, 0, 4'h0, 1, 0, 0, 0,        4'hF, 0,  4'hF, 0));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 1, 0, B+'h44,   4'hF, 10, 4'hF, 1));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          1, 1, 4'h0, 1, 0, 0, 0,        4'hF, 0,  4'hD, 0));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 1, 0, 1, B+'h100,    1, 0, 4'h3, 1, 0, 0, 0,        4'hF, 0,  4'hD, 0));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 1, 0, B+'h100,  4'h3, 11, 4'hD, 1));
    tbl.push_back(v(0, 4'h0, 0,     1, 2, 1, 3, 0, 0,          0, 0, 4'h0, 1, 0, 0, 0,        4'hF, 0,  4'hD, 0));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 1, 2, 'h108,    4'hF, 12, 4'hD, 1));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 1, 3, 'h108,    4'hF, 13, 4'hD, 1));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          0, 0, 4'h0, 1, 0, 0, 0,        4'hF, 0,  4'hD, 0));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          1, 0, 4'h0, 1, 0, 0, 0,        4'hF, 0,  4'hC, 0));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          1, 2, 4'h0, 1, 0, 0, 0,        4'hF, 0,  4'h8, 0));
    tbl.push_back(v(0, 4'h0, 0,     0, 0, 0, 0, 0, 0,          1, 3, 4'h0, 1, 0, 0, 0,        4'hF, 0,  4'h0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      start        = tbl[i].start;
      spawn_valid  = |tbl[i].spawn;
      spawn_wmask  = tbl[i].spawn;
      spawn_pc     = tbl[i].spc;
      unlock_valid = tbl[i].ul_v;
      unlock_wid   = tbl[i].ul_w;
      branch_valid = tbl[i].br_v;
      branch_wid   = tbl[i].br_w;
      branch_taken = tbl[i].br_t;
      branch_dest  = tbl[i].br_d;
      tmc_valid    = tbl[i].tm_v;
      tmc_wid      = tbl[i].tm_w;
      tmc_tmask    = tbl[i].tm_m;
      sched_ready  = tbl[i].rdy;
      if (tbl[i].nw) begin
        it.wid = tbl[i].e_w; it.pc = tbl[i].e_pc; it.tmask = tbl[i].e_tm; it.uuid = tbl[i].e_uid;
        exp_q.push_back(it);
      end
      tick();
      chk($sformatf("r%0d_valid", i), sched_valid, tbl[i].e_v);
      chk($sformatf("r%0d_active", i), active_warps, tbl[i].e_act);
      chk($sformatf("r%0d_busy", i), busy, |tbl[i].e_act);
      if (tbl[i].e_v) begin
        chk($sformatf("r%0d_wid", i), sched_wid, tbl[i].e_w);
        chk($sformatf("r%0d_pc", i), sched_pc, tbl[i].e_pc);
        chk($sformatf("r%0d_tmask", i), sched_tmask, tbl[i].e_tm);
        chk($sformatf("r%0d_uuid", i), sched_uuid, tbl[i].e_uid);
      end
    end
    clear_inputs();

    // Terminated warp already presented stays stable until accepted.
    sched_ready = 0;
    spawn_valid = 1; spawn_wmask = 4'b0010; spawn_pc = 32'h200;
    tick();
    clear_inputs();
    chk("term_spawn_active", active_warps, 4'b0010);
    it.wid = 1; it.pc = 32'h200; it.tmask = 4'hF; it.uuid = 14;
    exp_q.push_back(it);
    tick();
    chk("term_presented", {sched_valid, sched_wid, sched_pc}, {1'b1, 2'd1, 32'h200});
    tmc_valid = 1; tmc_wid = 1; tmc_tmask = 0;
    tick();
    clear_inputs();
    chk("term_active", active_warps, 0);
    chk("term_busy", busy, 0);
    chk("term_held", {sched_valid, sched_wid, sched_pc, sched_uuid}, {1'b1, 2'd1, 32'h200, 44'd14});
    sched_ready = 1;
    tick();
    chk("term_drained", sched_valid, 0);

    // Asynchronous reset with a transfer pending and no clock edge.
    sched_ready = 0;
    spawn_valid = 1; spawn_wmask = 4'b0001; spawn_pc = 32'h300;
    tick();
    clear_inputs();
    tick();
    chk("arst_pre", {sched_valid, sched_wid, sched_pc, sched_uuid}, {1'b1, 2'd0, 32'h300, 44'd15});
    #2 reset = 0;
    #1;
    chk("arst_valid", sched_valid, 0);
    chk("arst_active", active_warps, 0);
    chk("arst_uuid", sched_uuid, 0);
    @(posedge clk);
    #1 reset = 1;
    sched_ready = 1;

    // Boot after reset: uuid restarts at 0.
    start = 1;
    it.wid = 0; it.pc = B; it.tmask = 4'hF; it.uuid = 0;
    exp_q.push_back(it);
    f0 = fires;
    tick();
    start = 0;
    for (int k = 0; k < 10 && fires == f0; k++) tick();
    chk("boot2_fire", fires > f0, 1);
    chk("fire_total", fires, 16);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vx_warp_fetch_sched.md
Name: vx_warp_fetch_sched

Overview:
Per-core warp scheduler that sequences the fetch stage.
- Holds per-warp PC, thread mask, active and stall state.
- Picks one eligible warp per cycle, round-robin, and presents {wid, PC, tmask, uuid} to fetch on a valid/ready handshake.
- Allows one unresolved instruction per warp: the warp stalls on issue until decode/execute reports unlock, branch or tmc.

Parameters:
NUM_WARPS, 4, warps per core (power of 2, >=1)
NUM_THREADS, 4, threads per warp
XLEN, 32, PC width
UUID_WIDTH, 44, instruction trace id width
STARTUP_ADDR, 32'h80000000, warp-0 boot PC

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
start  in  1  pulse: activate warp 0 at STARTUP_ADDR, tmask all-ones
spawn_valid  in  1  activate warps in spawn_wmask
spawn_wmask  in  NUM_WARPS  warps to activate
spawn_pc  in  XLEN  start PC for spawned warps
unlock_valid  in  1  decoded instruction is not control flow
unlock_wid  in  NW_WIDTH  warp to unstall
branch_valid  in  1  branch resolved
branch_wid  in  NW_WIDTH  branch warp
branch_taken  in  1  branch taken
branch_dest  in  XLEN  taken target
tmc_valid  in  1  thread-mask change
tmc_wid  in  NW_WIDTH  target warp
tmc_tmask  in  NUM_THREADS  new mask (zero = terminate warp)
sched_valid  out  1  request to fetch
sched_ready  in  1  fetch accepts
sched_wid  out  NW_WIDTH  issued warp
sched_pc  out  XLEN  issued PC
sched_tmask  out  NUM_THREADS  issued mask
sched_uuid  out  UUID_WIDTH  issued id
active_warps  out  NUM_WARPS  active bitmap
busy  out  1  |active_warps

Behaviour:
- Reset (reset==0, async): all state zero; every output 0; RR pointer 0; uuid 0.
- Eligible set: eligible = active & ~stalled.
- Output register load:
  - Load when (!sched_valid || sched_ready) and eligible != 0.
  - Winner: first eligible warp at or after (last_issued+1) mod NUM_WARPS.
  - On load: register {wid, PC_w, tmask_w, uuid}; set stalled[w]; PC_w <= PC_w+4, wrapping mod 2^XLEN; uuid <= uuid+1, wrapping.
  - If the load condition holds but eligible == 0, sched_valid <= 0.
- Latency: a warp becoming eligible appears on sched_valid the next cycle.
- Back-to-back issue: a fire plus a new load in the same cycle gives continuous valid.
- Handshake: while sched_valid && !sched_ready, all sched_* outputs are held stable.
- start: active[0] <= 1, PC_0 <= STARTUP_ADDR, tmask_0 <= all-ones, stalled[0] <= 0. Ignored if warp 0 is already active.
- spawn: for each w in spawn_wmask with active[w]==0: active <= 1, PC <= spawn_pc, tmask <= all-ones, stalled <= 0. Already-active warps are unchanged.
- unlock: stalled[unlock_wid] <= 0.
- branch: stalled <= 0; if taken, PC <= branch_dest, otherwise PC is unchanged (already +4).
- tmc: stalled <= 0; tmask <= tmc_tmask; if tmc_tmask==0 then active <= 0.
- Simultaneous events, applied in order start, spawn, branch, tmc, unlock:
  - Branch and tmc on the same wid in one cycle: both apply.
  - Event on wid w in the same cycle w is loaded: the load uses pre-event state; the event's stall clear wins over the load's stall set. This case is legal only for a warp already stalled and therefore not loadable, so it cannot occur; assert it.
- Assertions:
  - Runtime assert: sched_valid implies sched_pc != 0.
  - Events targeting an inactive warp fire an assertion and are ignored.
- Terminated warp already in the output register: stays presented until accepted.

Decomposition:
- Package VX_gpu_pkg: NW_WIDTH = max(1, clog2(NUM_WARPS)); packed sched_data_t {uuid, wid, tmask, PC} shared with fetch.
- One sub-module: VX_rr_arbiter (NUM_REQS=NUM_WARPS), taking eligible and the enable and returning a one-hot/index grant.
- Per-warp state and the output register stay in this block.

Test Plan:
- Boot: deassert reset, pulse start, hold sched_ready=1 -> cycle+1: sched_valid=1, wid=0, pc=0x80000000, tmask=4'hF, uuid=0. Then valid=0 until unlock_wid=0; after unlock -> pc=0x80000004, uuid=1.
- Round-robin: spawn_wmask=4'b1110, spawn_pc=0x100, warp 0 unlocked each cycle -> issue order 0,1,2,3,0 with warps 1..3 at pc=0x100. Unlocks then yield pc 0x104.
- Backpressure: sched_ready=0 for 5 cycles with 2 eligible warps -> outputs held identical, no uuid/PC increment. On ready=1 -> fire, and the next warp is presented the following cycle.
- Branch: warp 0 issues pc 0x80000000, then branch_valid, taken=1, dest=0x80000040 -> next issue for warp 0 is pc=0x80000040. With taken=0 -> pc=0x80000004.
- Termination: tmc_wid=1, tmc_tmask=0 -> active_warps bit1 clears, warp 1 is never issued again. Last warp terminated -> busy=0, sched_valid=0.
- Async reset mid-stream: assert reset with sched_valid=1 and no clock edge -> sched_valid=0, active_warps=0 immediately.
